// File: rtl/fifo_stream_drain.sv
// Read-side drain stage for a synchronous FIFO: issues reads, absorbs the one-cycle read
// latency in a 3-entry skid buffer and presents words on a valid/ready stream.
module fifo_stream_drain #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic             fifo_underflow,
  input  logic [WIDTH-1:0] fifo_data_out,
  output logic             fifo_rd_en,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic [15:0]      word_count,
  output logic             err_underflow,
  output logic             busy
);

  logic [1:0]       occ_q, occ_d;
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] mem_q [3];
  logic [WIDTH-1:0] mem_d [3];
  logic [15:0]      count_q, count_d;
  logic             err_q, err_d;
  logic [2:0]       pending;
  logic             push, pop;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    // Reads depend only on registered occupancy, never on m_ready.
    pending       = {1'b0, occ_q} + {2'b00, inflight_q};
    fifo_rd_en    = enable && !flush && !fifo_empty && (pending < 3'd3);
    m_valid       = (occ_q != 2'd0);
    m_data        = mem_q[rd_ptr_q];
    busy          = m_valid || inflight_q;
    word_count    = count_q;
    err_underflow = err_q;

    push = inflight_q && !flush && !fifo_underflow;
    pop  = m_valid && m_ready;

    occ_d      = occ_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = fifo_rd_en;
    mem_d      = mem_q;
    count_d    = count_q;
    err_d      = err_q;

    if (inflight_q && !flush && fifo_underflow) err_d = 1'b1;
    if (pop) count_d = count_q + 16'd1;

    if (push) begin
      mem_d[wr_ptr_q] = fifo_data_out;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_next(rd_ptr_q);

    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    // Flush drops buffered words and the in-flight read; handshake still counts.
    if (flush) begin
      occ_d      = 2'd0;
      wr_ptr_d   = 2'd0;
      rd_ptr_d   = 2'd0;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= 2'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      inflight_q <= 1'b0;
      mem_q      <= '{default: '0};
      count_q    <= 16'd0;
      err_q      <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      mem_q      <= mem_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: behavioural FIFO model upstream, scoreboard of expected
// stream words checked on every handshake.
module tb_fifo_stream_drain;
  localparam int unsigned W = 16;

  logic         clk, rst_n, enable, flush, fifo_empty, fifo_underflow;
  logic [W-1:0] fifo_data_out;
  logic         fifo_rd_en, m_valid, m_ready;
  logic [W-1:0] m_data;
  logic [15:0]  word_count;
  logic         err_underflow, busy;

  int checks;
  int errors;

  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];
  logic         uf_pending;
  logic         s_rst, s_rd_en, s_valid, s_busy, s_err;
  logic [15:0]  s_wc;
  logic         stall_prev;
  logic [W-1:0] stall_data;

  fifo_stream_drain #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .flush         (flush),
    .fifo_empty    (fifo_empty),
    .fifo_underflow(fifo_underflow),
    .fifo_data_out (fifo_data_out),
    .fifo_rd_en    (fifo_rd_en),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready),
    .word_count    (word_count),
    .err_underflow (err_underflow),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Samples the cycle at negedge, scores handshakes, then advances the FIFO model one edge.
  task automatic clk_step();
    logic [W-1:0] e;
    @(negedge clk);
    s_rst   = rst_n;
    s_rd_en = fifo_rd_en;
    s_valid = m_valid;
    s_busy  = busy;
    s_err   = err_underflow;
    s_wc    = word_count;
    if (rst_n && m_valid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra_word got %0h expected none", m_data);
      end else begin
        e = exp_q.pop_front();
        if (m_data !== e) begin
          errors++;
          $display("FAIL sb_data got %0h expected %0h", m_data, e);
        end
      end
    end
    if (stall_prev) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== stall_data) begin
        errors++;
        $display("FAIL stall_hold got valid %b data %0h expected valid 1 data %0h",
                 m_valid, m_data, stall_data);
      end
    end
    stall_prev = rst_n && !flush && m_valid && !m_ready;
    stall_data = m_data;
    @(posedge clk);
    fifo_underflow <= 1'b0;
    if (s_rst && s_rd_en) begin
      if (uf_pending || fq.size() == 0) begin
        fifo_underflow <= 1'b1;
        fifo_data_out  <= 16'hDEAD;
        uf_pending = 1'b0;
      end else begin
        fifo_data_out <= fq.pop_front();
      end
    end
    fifo_empty <= (fq.size() == 0);
    #1;
  endtask

  task automatic load(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      fq.push_back(base + 16'(i));
      exp_q.push_back(base + 16'(i));
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    enable  = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;
    fq.delete();
    exp_q.delete();
    uf_pending = 1'b0;
    stall_prev = 1'b0;
  endtask

  task automatic release_rst();
    clk_step();
    clk_step();
    rst_n  = 1'b1;
    enable = 1'b1;
  endtask

  task automatic drain(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (exp_q.size() == 0 && !busy && fq.size() == 0) break;
      clk_step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({fifo_rd_en, m_valid, m_data, word_count, err_underflow, busy} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs got rd %b v %b d %0h wc %0h err %b busy %b expected all 0",
               fifo_rd_en, m_valid, m_data, word_count, err_underflow, busy);
    end
  endtask

  task automatic test_stream();
    logic e_rd, e_v;
    do_reset();
    load(5, 16'h0001);
    m_ready = 1'b1;
    release_rst();
    for (int c = 0; c < 8; c++) begin
      clk_step();
      e_rd = (c < 5);
      e_v  = (c >= 2 && c <= 6);
      checks += 2;
      if (s_rd_en !== e_rd) begin
        errors++;
        $display("FAIL stream_rd_en c%0d got %b expected %b", c, s_rd_en, e_rd);
      end
      if (s_valid !== e_v) begin
        errors++;
        $display("FAIL stream_valid c%0d got %b expected %b", c, s_valid, e_v);
      end
    end
    checks += 3;
    if (s_busy !== 1'b0) begin
      errors++;
      $display("FAIL stream_busy_c7 got %b expected 0", s_busy);
    end
    if (s_wc !== 16'd5) begin
      errors++;
      $display("FAIL stream_count got %0d expected 5", s_wc);
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_left got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int nrd;
    do_reset();
    load(8, 16'h0100);
    release_rst();
    nrd = 0;
    for (int i = 0; i < 10; i++) begin
      clk_step();
      if (s_rd_en) nrd++;
    end
    checks += 3;
    if (nrd != 3) begin
      errors++;
      $display("FAIL bp_reads got %0d expected 3", nrd);
    end
    if (s_rd_en !== 1'b0 || s_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold got rd %b valid %b expected rd 0 valid 1", s_rd_en, s_valid);
    end
    if (s_wc !== 16'd0) begin
      errors++;
      $display("FAIL bp_count_stalled got %0d expected 0", s_wc);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) clk_step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_no_gap got %0d left expected 0", exp_q.size());
    end
    clk_step();
    checks++;
    if (s_wc !== 16'd8) begin
      errors++;
      $display("FAIL bp_count got %0d expected 8", s_wc);
    end
  endtask

  task automatic test_toggle();
    do_reset();
    load(12, 16'h0200);
    m_ready = 1'b1;
    release_rst();
    for (int i = 0; i < 30; i++) begin
      m_ready = (i % 2 == 0);
      clk_step();
    end
    m_ready = 1'b1;
    drain(40);
    checks += 2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL toggle_left got %0d expected 0", exp_q.size());
    end
    if (word_count !== 16'd12) begin
      errors++;
      $display("FAIL toggle_count got %0d expected 12", word_count);
    end
  endtask

  task automatic test_flush();
    do_reset();
    load(6, 16'h0300);
    release_rst();
    clk_step();
    clk_step();
    clk_step();
    flush = 1'b1;
    clk_step();
    checks++;
    if (s_rd_en !== 1'b0 || s_valid !== 1'b1 || s_busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre got rd %b valid %b busy %b expected 0 1 1",
               s_rd_en, s_valid, s_busy);
    end
    flush = 1'b0;
    clk_step();
    checks += 2;
    if (s_valid !== 1'b0 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear got valid %b busy %b expected 0 0", s_valid, s_busy);
    end
    if (s_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL flush_resume got rd %b expected 1", s_rd_en);
    end
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    m_ready = 1'b1;
    drain(40);
    checks += 2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL flush_left got %0d expected 0", exp_q.size());
    end
    if (word_count !== 16'd3) begin
      errors++;
      $display("FAIL flush_count got %0d expected 3", word_count);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    uf_pending = 1'b1;
    load(4, 16'h0400);
    m_ready = 1'b1;
    release_rst();
    drain(40);
    checks += 3;
    if (err_underflow !== 1'b1) begin
      errors++;
      $display("FAIL uf_set got %b expected 1", err_underflow);
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL uf_left got %0d expected 0", exp_q.size());
    end
    if (word_count !== 16'd4) begin
      errors++;
      $display("FAIL uf_count got %0d expected 4", word_count);
    end
    load(3, 16'h0500);
    drain(40);
    checks += 2;
    if (err_underflow !== 1'b1) begin
      errors++;
      $display("FAIL uf_sticky got %b expected 1", err_underflow);
    end
    if (word_count !== 16'd7) begin
      errors++;
      $display("FAIL uf_count2 got %0d expected 7", word_count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL uf_reset got %b expected 0", err_underflow);
    end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    load(65535, 16'h0000);
    m_ready = 1'b1;
    release_rst();
    for (int i = 0; i < 70000; i++) begin
      clk_step();
      if (s_wc == 16'hFFFF) break;
    end
    checks++;
    if (s_wc !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_reach got %0h expected ffff", s_wc);
    end
    m_ready = 1'b0;
    load(3, 16'h0600);
    for (int i = 0; i < 7; i++) clk_step();
    checks++;
    if (s_valid !== 1'b1 || s_busy !== 1'b1 || s_rd_en !== 1'b0 || s_wc !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_full got v %b busy %b rd %b wc %0h expected 1 1 0 ffff",
               s_valid, s_busy, s_rd_en, s_wc);
    end
    m_ready = 1'b1;
    clk_step();
    m_ready = 1'b0;
    clk_step();
    checks++;
    if (s_wc !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_count got %0h expected 0", s_wc);
    end
    load(1, 16'h0700);
    for (int i = 0; i < 4; i++) clk_step();
    checks++;
    if (s_valid !== 1'b1 || s_rd_en !== 1'b0 || s_busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_full got v %b rd %b busy %b expected 1 0 1", s_valid, s_rd_en, s_busy);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({fifo_rd_en, m_valid, m_data, word_count, err_underflow, busy} !== 35'd0) begin
      errors++;
      $display("FAIL rst_mid got rd %b v %b d %0h wc %0h err %b busy %b expected all 0",
               fifo_rd_en, m_valid, m_data, word_count, err_underflow, busy);
    end
    exp_q.delete();
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    enable         = 1'b0;
    flush          = 1'b0;
    m_ready        = 1'b0;
    fifo_empty     = 1'b1;
    fifo_underflow = 1'b0;
    fifo_data_out  = '0;
    uf_pending     = 1'b0;
    stall_prev     = 1'b0;
    stall_data     = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_flush();
    test_underflow();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
